// File: rtl/rv_plic_claim_pkg.sv
// Shared types and constants for the PLIC per-target claim/complete sequencer.
// Optional build macro RV_PLIC_CLAIM_ERR_EN (see rv_plic_claim_ctrl.sv) adds a
// sticky error flag for invalid completions.
package rv_plic_claim_pkg;

    // Claim sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESP   = 2'd1,
        ST_SETTLE = 2'd2
    } claim_state_e;

    // Settle counter width; SETTLE_CYCLES is limited to 1..7.
    localparam int unsigned SETTLE_CNT_W = 3;
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_CNT_ZERO = 3'd0;
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_CNT_ONE  = 3'd1;

    // Trigger-mode encodings carried on le_i.
    localparam logic LE_LEVEL = 1'b0;
    localparam logic LE_EDGE  = 1'b1;

    // Gateway set condition for one source, shared by all gateway instances.
    function automatic logic gw_set(input logic le, input logic src,
                                    input logic prev, input logic ip,
                                    input logic ia);
        logic set_v;
        if (ia) begin
            set_v = 1'b0;
        end else if (le == LE_EDGE) begin
            set_v = src & ~prev;
        end else begin
            set_v = src & ~ip;
        end
        return set_v;
    endfunction

endpackage

// File: rtl/rv_plic_gateway.sv
// Single-source interrupt gateway: holds pending (ip), in-service (ia) and the
// previous source level used for rising-edge detection.
module rv_plic_gateway
    import rv_plic_claim_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic src,
    input  logic le,
    input  logic claim_clr,
    input  logic complete_sel,
    output logic ip,
    output logic ia,
    output logic complete_hit
);

    logic ip_r;
    logic ia_r;
    logic prev_r;
    logic set_s;

    // New pending request; blocked while in service, edges are not queued.
    always_comb begin
        set_s = 1'b0;
        set_s = gw_set(le, src, prev_r, ip_r, ia_r);
    end

    // Pending/in-service state; a claim clear takes priority over a new set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ip_r   <= 1'b0;
            ia_r   <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            prev_r <= src;
            if (claim_clr) begin
                ip_r <= 1'b0;
                ia_r <= 1'b1;
            end else begin
                if (set_s) begin
                    ip_r <= 1'b1;
                end
                if (complete_sel && ia_r) begin
                    ia_r <= 1'b0;
                end
            end
        end
    end

    assign ip           = ip_r;
    assign ia           = ia_r;
    assign complete_hit = complete_sel & ia_r;

endmodule

// File: rtl/rv_plic_claim_ctrl.sv
// Per-target PLIC gateway array plus claim/complete sequencer.
// Optional macro RV_PLIC_CLAIM_ERR_EN: adds err_clr_i/err_o, a sticky flag set
// by completions that are zero, out of range or not in service.
module rv_plic_claim_ctrl
    import rv_plic_claim_pkg::*;
#(
    parameter int unsigned N_SOURCE      = 32,
    parameter int unsigned SETTLE_CYCLES = 1,
    localparam int unsigned SrcWidth     = $clog2(N_SOURCE)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_SOURCE-1:0] src_i,
    input  logic [N_SOURCE-1:0] le_i,
    output logic [N_SOURCE-1:0] ip_o,
    input  logic                tgt_irq_i,
    input  logic [SrcWidth-1:0] tgt_irq_id_i,
    input  logic                claim_valid_i,
    output logic                claim_ready_o,
    output logic [SrcWidth-1:0] claim_id_o,
    input  logic                complete_valid_i,
    input  logic [SrcWidth-1:0] complete_id_i,
`ifdef RV_PLIC_CLAIM_ERR_EN
    input  logic                err_clr_i,
    output logic                err_o,
`endif
    output logic [N_SOURCE-1:0] ia_o
);

    claim_state_e              state_r;
    logic [SETTLE_CNT_W-1:0]   cnt_r;
    logic                      ready_r;
    logic [SrcWidth-1:0]       id_r;
    logic [SrcWidth-1:0]       claim_id_s;
    logic                      claim_fire_s;
    logic [N_SOURCE-1:0]       comp_hit_s;

    // ID returned for a claim accepted this cycle (0 when nothing qualifies).
    always_comb begin
        claim_id_s   = {SrcWidth{1'b0}};
        claim_fire_s = 1'b0;
        if (tgt_irq_i) begin
            claim_id_s = tgt_irq_id_i;
        end else begin
            claim_id_s = {SrcWidth{1'b0}};
        end
        if ((state_r == ST_IDLE) && claim_valid_i && (claim_id_s != {SrcWidth{1'b0}})) begin
            claim_fire_s = 1'b1;
        end else begin
            claim_fire_s = 1'b0;
        end
    end

    // Claim sequencer: accept in IDLE, answer in RESP, let the tree settle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            cnt_r   <= SETTLE_CNT_ZERO;
            ready_r <= 1'b0;
            id_r    <= {SrcWidth{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (claim_valid_i) begin
                        id_r    <= claim_id_s;
                        ready_r <= 1'b1;
                        state_r <= ST_RESP;
                    end else begin
                        ready_r <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RESP: begin
                    ready_r <= 1'b0;
                    cnt_r   <= SETTLE_CNT_W'(SETTLE_CYCLES);
                    state_r <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    ready_r <= 1'b0;
                    cnt_r   <= cnt_r - SETTLE_CNT_ONE;
                    if (cnt_r <= SETTLE_CNT_ONE) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_SETTLE;
                    end
                end
                default: begin
                    ready_r <= 1'b0;
                    cnt_r   <= SETTLE_CNT_ZERO;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign claim_ready_o = ready_r;
    assign claim_id_o    = id_r;

    // ID 0 is reserved: never pending, never in service.
    assign ip_o[0]       = 1'b0;
    assign ia_o[0]       = 1'b0;
    assign comp_hit_s[0] = 1'b0;

    for (genvar k = 1; k < N_SOURCE; k++) begin : g_src
        logic claim_hit_s;
        logic comp_sel_s;
        assign claim_hit_s = claim_fire_s && (tgt_irq_id_i == SrcWidth'(k));
        assign comp_sel_s  = complete_valid_i && (complete_id_i == SrcWidth'(k));

        rv_plic_gateway u_gw (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .src          (src_i[k]),
            .le           (le_i[k]),
            .claim_clr    (claim_hit_s),
            .complete_sel (comp_sel_s),
            .ip           (ip_o[k]),
            .ia           (ia_o[k]),
            .complete_hit (comp_hit_s[k])
        );
    end

    // Source 0 inputs have no gateway.
    logic unused_src0_s;
    assign unused_src0_s = src_i[0] ^ le_i[0];

`ifdef RV_PLIC_CLAIM_ERR_EN
    logic err_r;
    logic bad_comp_s;

    // A completion that matched no in-service source is an error.
    always_comb begin
        bad_comp_s = 1'b0;
        if (complete_valid_i && (comp_hit_s == {N_SOURCE{1'b0}})) begin
            bad_comp_s = 1'b1;
        end else begin
            bad_comp_s = 1'b0;
        end
    end

    // Sticky error flag; a new error outranks a simultaneous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_r <= 1'b0;
        end else if (bad_comp_s) begin
            err_r <= 1'b1;
        end else if (err_clr_i) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r;
        end
    end

    assign err_o = err_r;
`else
    logic unused_comp_s;
    assign unused_comp_s = |comp_hit_s;
`endif

endmodule

// File: tb/tb_rv_plic_claim_ctrl.sv
// Directed self-checking bench for rv_plic_claim_ctrl (N_SOURCE=32, SETTLE_CYCLES=1).
module tb_rv_plic_claim_ctrl;

    localparam int unsigned NS = 32;
    localparam int unsigned SW = 5;

    logic          clk;
    logic          rst_ni;
    logic [NS-1:0] src;
    logic [NS-1:0] le;
    logic [NS-1:0] ip;
    logic          tgt_irq;
    logic [SW-1:0] tgt_id;
    logic          claim_valid;
    logic          claim_ready;
    logic [SW-1:0] claim_id;
    logic          complete_valid;
    logic [SW-1:0] complete_id;
    logic [NS-1:0] ia;
`ifdef RV_PLIC_CLAIM_ERR_EN
    logic          err_clr;
    logic          err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    rv_plic_claim_ctrl #(.N_SOURCE(NS), .SETTLE_CYCLES(1)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .src_i            (src),
        .le_i             (le),
        .ip_o             (ip),
        .tgt_irq_i        (tgt_irq),
        .tgt_irq_id_i     (tgt_id),
        .claim_valid_i    (claim_valid),
        .claim_ready_o    (claim_ready),
        .claim_id_o       (claim_id),
        .complete_valid_i (complete_valid),
        .complete_id_i    (complete_id),
`ifdef RV_PLIC_CLAIM_ERR_EN
        .err_clr_i        (err_clr),
        .err_o            (err),
`endif
        .ia_o             (ia)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni = 1'b0; src = '0; le = 32'h0000_0008; tgt_irq = 1'b0; tgt_id = '0;
        claim_valid = 1'b0; complete_valid = 1'b0; complete_id = '0;
`ifdef RV_PLIC_CLAIM_ERR_EN
        err_clr = 1'b0;
`endif
        tick(); tick();
        chk("rst_ip", ip, 32'h0);
        chk("rst_ia", ia, 32'h0);
        chk("rst_ready", {31'd0, claim_ready}, 32'd0);
        chk("rst_id", {27'd0, claim_id}, 32'd0);
`ifdef RV_PLIC_CLAIM_ERR_EN
        chk("rst_err", {31'd0, err}, 32'd0);
`endif
        rst_ni = 1'b1;
        tick();

        // Level source 5: pend, claim, complete with source still high.
        src[5] = 1'b1; tick();
        chk("lvl_pend", ip, 32'h0000_0020);
        tgt_irq = 1'b1; tgt_id = 5'd5; claim_valid = 1'b1; tick();
        chk("lvl_ready", {31'd0, claim_ready}, 32'd1);
        chk("lvl_id", {27'd0, claim_id}, 32'd5);
        chk("lvl_ip_clr", ip, 32'h0);
        chk("lvl_ia_set", ia, 32'h0000_0020);
        claim_valid = 1'b0; tgt_irq = 1'b0; tick();
        chk("lvl_ready_pulse", {31'd0, claim_ready}, 32'd0);
        tick();
        complete_valid = 1'b1; complete_id = 5'd5; tick();
        complete_valid = 1'b0;
        chk("lvl_ia_clr", ia, 32'h0);
        chk("lvl_ip_wait", ip, 32'h0);
        tick();
        chk("lvl_repend", ip, 32'h0000_0020);
        // Drain source 5 with the source low: no re-pend.
        src[5] = 1'b0; tgt_irq = 1'b1; tgt_id = 5'd5; claim_valid = 1'b1; tick();
        claim_valid = 1'b0; tgt_irq = 1'b0;
        chk("lvl2_ia", ia, 32'h0000_0020);
        tick(); tick();
        complete_valid = 1'b1; complete_id = 5'd5; tick();
        complete_valid = 1'b0; tick();
        chk("lvl2_no_repend", ip, 32'h0);
        chk("lvl2_ia", ia, 32'h0);

        // Edge source 3: edges while in service are dropped.
        src[3] = 1'b1; tick();
        chk("edge_pend", ip, 32'h0000_0008);
        tgt_irq = 1'b1; tgt_id = 5'd3; claim_valid = 1'b1; tick();
        claim_valid = 1'b0; tgt_irq = 1'b0;
        chk("edge_id", {27'd0, claim_id}, 32'd3);
        chk("edge_ia", ia, 32'h0000_0008);
        for (int i = 0; i < 3; i++) begin
            src[3] = 1'b0; tick();
            src[3] = 1'b1; tick();
        end
        chk("edge_drop", ip, 32'h0);
        src[3] = 1'b0;
        complete_valid = 1'b1; complete_id = 5'd3; tick();
        complete_valid = 1'b0;
        chk("edge_ia_clr", ia, 32'h0);
        tick();
        chk("edge_no_queue", ip, 32'h0);
        src[3] = 1'b1; tick();
        chk("edge_new", ip, 32'h0000_0008);

        // Empty claims held back-to-back: responses at t+1 and t+4 only.
        tgt_irq = 1'b0; tgt_id = 5'd3; claim_valid = 1'b1; tick();
        chk("b2b_r1", {31'd0, claim_ready}, 32'd1);
        chk("b2b_id0", {27'd0, claim_id}, 32'd0);
        chk("b2b_ip", ip, 32'h0000_0008);
        chk("b2b_ia", ia, 32'h0);
        tick();
        chk("b2b_r2", {31'd0, claim_ready}, 32'd0);
        tick();
        chk("b2b_r3", {31'd0, claim_ready}, 32'd0);
        tick();
        chk("b2b_r4", {31'd0, claim_ready}, 32'd1);
        claim_valid = 1'b0;
        tick();
        chk("b2b_r5", {31'd0, claim_ready}, 32'd0);
        chk("b2b_hold_id", {27'd0, claim_id}, 32'd0);
        tick();

        // Claim 3, then claim 9 while completing 3 in the same cycle.
        tgt_irq = 1'b1; tgt_id = 5'd3; claim_valid = 1'b1; tick();
        claim_valid = 1'b0; tgt_irq = 1'b0;
        tick(); tick();
        src[9] = 1'b1; tick();
        chk("sim_pend9", ip, 32'h0000_0200);
        tgt_irq = 1'b1; tgt_id = 5'd9; claim_valid = 1'b1;
        complete_valid = 1'b1; complete_id = 5'd3; tick();
        claim_valid = 1'b0; tgt_irq = 1'b0; complete_valid = 1'b0;
        chk("sim_ia", ia, 32'h0000_0200);
        chk("sim_ip", ip, 32'h0);
        chk("sim_id", {27'd0, claim_id}, 32'd9);
`ifdef RV_PLIC_CLAIM_ERR_EN
        chk("sim_err", {31'd0, err}, 32'd0);
`endif
        tick(); tick();

        // Invalid completions leave ia untouched.
        complete_valid = 1'b1; complete_id = 5'd7; tick();
        chk("bad7_ia", ia, 32'h0000_0200);
`ifdef RV_PLIC_CLAIM_ERR_EN
        chk("bad7_err", {31'd0, err}, 32'd1);
`endif
        complete_id = 5'd0; tick();
        complete_valid = 1'b0;
        chk("bad0_ia", ia, 32'h0000_0200);
`ifdef RV_PLIC_CLAIM_ERR_EN
        err_clr = 1'b1; tick();
        chk("err_clr", {31'd0, err}, 32'd0);
        complete_valid = 1'b1; complete_id = 5'd0; tick();
        chk("err_set_wins", {31'd0, err}, 32'd1);
        complete_valid = 1'b0; tick();
        err_clr = 1'b0;
        chk("err_clr2", {31'd0, err}, 32'd0);
`endif

        // Complete 9 with source high: re-pends one cycle after ia clears.
        complete_valid = 1'b1; complete_id = 5'd9; tick();
        complete_valid = 1'b0;
        chk("c9_ia", ia, 32'h0);
        tick();
        chk("c9_repend", ip, 32'h0000_0200);

        // Reset during RESP: no response, state cleared immediately.
        tgt_irq = 1'b1; tgt_id = 5'd9; claim_valid = 1'b1; tick();
        claim_valid = 1'b0; tgt_irq = 1'b0;
        chk("rr_ready", {31'd0, claim_ready}, 32'd1);
        rst_ni = 1'b0; #1;
        chk("rr_ready0", {31'd0, claim_ready}, 32'd0);
        chk("rr_ip0", ip, 32'h0);
        chk("rr_ia0", ia, 32'h0);
        src = '0;
        tick();
        rst_ni = 1'b1;
        tick(); tick();
        chk("rr_idle_ready", {31'd0, claim_ready}, 32'd0);
        chk("rr_ip_after", ip, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rv_plic_claim_ctrl.md
Name: rv_plic_claim_ctrl

Overview:
Per-target gateway and claim/complete sequencer for the PLIC.
- Turns raw interrupt sources into pending bits (ip_o), which feed the priority/threshold selection tree.
- Serves claim reads by returning the winning ID from that tree, and tracks in-service sources until they are completed.
- Sits between the register-interface decode and the selection tree: one instance per target.

Parameters:
N_SOURCE, 32, number of interrupt sources; ID 0 is reserved and never pends.
SETTLE_CYCLES, 1, cycles the selection tree needs after an ip_o change before tgt_irq_id_i is valid again; range 1..7.
SrcWidth, $clog2(N_SOURCE), localparam, ID width.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous, active-low reset.
src_i  in  N_SOURCE  interrupt source levels, already synchronous to clk_i.
le_i  in  N_SOURCE  per-source trigger mode: 1 = edge (rising), 0 = level.
ip_o  out  N_SOURCE  registered pending bits to the selection tree.
tgt_irq_i  in  1  selection tree reports a pending interrupt above threshold.
tgt_irq_id_i  in  SrcWidth  winning ID from the selection tree.
claim_valid_i  in  1  claim-register read request.
claim_ready_o  out  1  claim response strobe, one cycle.
claim_id_o  out  SrcWidth  claimed ID; 0 when nothing is pending.
complete_valid_i  in  1  complete-register write strobe.
complete_id_i  in  SrcWidth  ID being completed.
ia_o  out  N_SOURCE  in-service bitmap, for debug and status.

Behaviour:
Reset:
- ip_o=0, ia_o=0, claim_ready_o=0, claim_id_o=0.
- FSM in IDLE, settle counter 0, edge-history registers 0.

Gateway, per source k≥1:
- Level mode: ip[k] sets when src_i[k]=1 and ip[k]=0 and ia[k]=0.
- Edge mode: ip[k] sets on src_i[k] rising (src_i[k]=1 and prev[k]=0) and ia[k]=0. Edges while ip[k]=1 or ia[k]=1 are dropped, not queued.
- prev[k] samples src_i[k] every cycle.
- Source 0: ip[0] and ia[0] are tied 0.

FSM states IDLE, RESP, SETTLE:
- IDLE, claim_valid_i=1 at cycle t:
  - Latch id = tgt_irq_i ? tgt_irq_id_i : 0, then go to RESP.
  - If id≠0, at the t→t+1 edge clear ip[id] and set ia[id].
- RESP (cycle t+1): claim_ready_o=1 and claim_id_o=latched id. Load counter with SETTLE_CYCLES, go to SETTLE.
- SETTLE: decrement the counter; at 1, go to IDLE. claim_valid_i is ignored here and must be held by the requester until claim_ready_o.
- Claim latency is fixed: response at t+1. Next claim accepted at t+2+SETTLE_CYCLES.
- SETTLE runs even when the claimed ID is 0.
- claim_id_o holds its last value between responses and is only meaningful when claim_ready_o=1.

Completion:
- Accepted in any FSM state; there is no ready signal.
- If complete_id_i≠0, complete_id_i<N_SOURCE and ia[complete_id_i]=1, clear ia[id] at the next edge. Otherwise the write is ignored.
- A level source still high re-pends on the cycle after ia clears.

Simultaneous events:
- Claim-clear and gateway-set on the same source in the same cycle: the clear wins. ia is set, so the set is blocked anyway.
- Completion of k in the same cycle as a claim of j≠k: both take effect.
- Reset mid-claim: FSM returns to IDLE and no response is issued.

Optional Feature:
RV_PLIC_CLAIM_ERR_EN
- Defined: adds output err_o (1 bit, reset 0). err_o sets sticky on any completion whose ID is 0, out of range, or not in service. A one-cycle err_clr_i input clears it; a simultaneous set wins over the clear.
- Undefined: err_o and err_clr_i are absent, and invalid completions are silently ignored.

Decomposition:
- Package rv_plic_claim_pkg holds:
  - the FSM state enum (IDLE, RESP, SETTLE);
  - the settle counter width constant (3 bits);
  - the trigger-mode constants LE_LEVEL=0, LE_EDGE=1.
- Sub-module rv_plic_gateway: a single-source edge/level gateway holding the ip, ia and prev bits, instantiated N_SOURCE-1 times in a generate loop.

Test Plan:
- Level source 5 high, tgt_irq_id_i=5, tgt_irq_i=1, claim at t → claim_ready_o=1 with claim_id_o=5 at t+1; ip_o[5]=0 and ia_o[5]=1 from t+1. Complete 5 with src still high → ip_o[5]=1 two cycles after the complete strobe.
- Edge source 3, three rising edges while in service → no re-pend. After completion, one new edge → ip_o[3]=1 one cycle after the edge.
- tgt_irq_i=0, claim → claim_id_o=0; ip_o and ia_o unchanged; the next claim is not answered before t+2+SETTLE_CYCLES.
- Back-to-back claims with claim_valid_i held high, SETTLE_CYCLES=1 → claim_ready_o pulses at t+1 and t+4, never in between.
- Complete ID 7 when ia_o[7]=0, and complete ID 0 → ia_o unchanged. With RV_PLIC_CLAIM_ERR_EN defined, err_o=1 from the next cycle.
- Assert rst_ni during RESP → claim_ready_o=0 immediately; ip_o=0 and ia_o=0.
